// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Imported by the receiver top level.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Receive-line front end: 2-flop synchroniser, falling-edge detector and a
// 3-sample majority vote taken around mid-bit.
module uart_bit_sampler #(
   parameter int unsigned DIV = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   uart_rxd,
   input  logic [$clog2(DIV)-1:0] count,
   output logic                   start_edge,
   output logic                   bit_val
);

   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] C_S0 = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] C_S1 = CW'(DIV / 2);

   logic sync1_q, sync2_q, rxd_d;
   logic s0_q, s1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         rxd_d   <= 1'b1;
         s0_q    <= 1'b1;
         s1_q    <= 1'b1;
      end else begin
         sync1_q <= uart_rxd;
         sync2_q <= sync1_q;
         rxd_d   <= sync2_q;
         if (count == C_S0) s0_q <= sync2_q;
         if (count == C_S1) s1_q <= sync2_q;
      end
   end

   assign start_edge = rxd_d & ~sync2_q;

   // Third sample is the live synchronised value, so the vote is ready at DIV/2+1.
   assign bit_val = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, optional run-time
// even/odd parity, 1 or 2 stop bits, valid/ready delivery with error status.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 1000000,
   parameter int unsigned BAUD_RATE = 100000,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY_EN = 1,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 uart_rxd,
   input  logic                 parity_mode,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CW  = $clog2(DIV);
   localparam int unsigned BW  = $clog2(DATA_BITS);

   localparam logic [CW-1:0] C_DEC   = CW'(DIV / 2 + 1);
   localparam logic [CW-1:0] C_LAST  = CW'(DIV - 1);
   localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);
   localparam logic          SC_LAST = 1'(STOP_BITS - 1);

   if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2)
   begin : g_param_check
      $error("uart_rx_param: illegal parameters (DIV >= 4, DATA_BITS 5..9, STOP_BITS 1..2)");
   end

   rx_state_e            state;
   logic [CW-1:0]        count;
   logic [BW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_mode_q;
   logic                 par_err_q;
   logic                 stop_ok_q;
   logic                 start_edge;
   logic                 bit_val;
   logic                 exp_par;

   uart_bit_sampler #(
      .DIV (DIV)
   ) u_sampler (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_rxd   (uart_rxd),
      .count      (count),
      .start_edge (start_edge),
      .bit_val    (bit_val)
   );

   assign exp_par = (par_mode_q == PAR_ODD) ? ~^shift_q : ^shift_q;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         bit_cnt     <= '0;
         stop_cnt    <= 1'b0;
         shift_q     <= '0;
         par_mode_q  <= PAR_EVEN;
         par_err_q   <= 1'b0;
         stop_ok_q   <= 1'b1;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         count <= (count == C_LAST) ? '0 : count + CW'(1);

         unique case (state)
            IDLE: begin
               count    <= '0;
               bit_cnt  <= '0;
               stop_cnt <= 1'b0;
               if (start_edge) begin
                  state     <= START;
                  par_err_q <= 1'b0;
                  stop_ok_q <= 1'b1;
               end
            end
            START: begin
               if (count == C_LAST) state <= DATA;
               // Decision is applied last so a false start wins even when DIV=4.
               if (count == C_DEC) begin
                  if (bit_val) begin
                     state <= IDLE;
                     count <= '0;
                  end else begin
                     par_mode_q <= parity_mode;
                  end
               end
            end
            DATA: begin
               if (count == C_DEC) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
               if (count == C_LAST) begin
                  if (bit_cnt == BC_LAST) begin
                     bit_cnt <= '0;
                     state   <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            PARITY: begin
               if (count == C_DEC) par_err_q <= bit_val ^ exp_par;
               if (count == C_LAST) state <= STOP;
            end
            STOP: begin
               if (count == C_LAST && stop_cnt != SC_LAST) stop_cnt <= 1'b1;
               if (count == C_DEC) begin
                  if (stop_cnt == SC_LAST) begin
                     // Commit at the last stop decision so a back-to-back start is not missed.
                     state <= IDLE;
                     count <= '0;
                     if (!rx_valid || rx_ready) begin
                        rx_data    <= shift_q;
                        parity_err <= par_err_q;
                        frame_err  <= ~(stop_ok_q & bit_val);
                        rx_valid   <= 1'b1;
                     end else begin
                        overrun_err <= 1'b1;
                     end
                  end else begin
                     stop_ok_q <= stop_ok_q & bit_val;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
